// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial UART-style frame transmitter.
// Frame: start bit (0), DATA_W data bits LSB first, optional even parity, stop bit (1).
// Each bit is held for CLKS_PER_BIT clock cycles; q is a registered output.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds the even-parity bit).
module serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              q,
  output logic              busy
);

  localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CountW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [CountW-1:0] CountLast = CountW'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [CountW-1:0]   count_q, count_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                q_q, q_d;
  logic                bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign bit_end = (timer_q == TimerLast);

  // Next-state logic: bit timer, bit counter, shift register and FSM transitions.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    shift_d = shift_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          state_d = StStart;
          shift_d = data_in;
          timer_d = '0;
          count_d = '0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = StData;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (count_q == CountLast) begin
            count_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            count_d = count_q + CountW'(1);
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = StStop;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line value for the upcoming cycle, derived from next state so q stays a pure flop.
  always_comb begin
    q_d = 1'b1;
    unique case (state_d)
      StStart:  q_d = 1'b0;
      StData:   q_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      StParity: q_d = parity_d;
`endif
      default:  q_d = 1'b1;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      count_q <= '0;
      shift_q <= '0;
      q_q     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      shift_q <= shift_d;
      q_q     <= q_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign q         = q_q;
  assign ready_out = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_tx.sv
// Directed self-checking bench for serial_tx (DATA_W=8, CLKS_PER_BIT=4).
// Expected frames are built from hand-computed data and parity constants.
module tb_serial_tx;

  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME_CYC = FB * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, q, busy;

  int checks = 0;
  int errors = 0;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .q         (q),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Advance one cycle; outputs are then settled for the new cycle.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Frame bit k (0 = start). p is the hand-computed even parity; bit 10 is unused without parity.
  function automatic logic [10:0] frame(input logic [7:0] d, input logic p);
`ifdef SERIAL_TX_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    return {p, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic handshake(input logic [7:0] d);
    valid_in = 1'b1;
    data_in  = d;
    step();
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (q !== 1'b1 || ready_out !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got q=%b rdy=%b busy=%b want 1 1 0", i, q, ready_out, busy);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [10:0] exp;
    exp = frame(8'hA5, 1'b0);
    handshake(8'hA5);
    for (int k = 0; k < FRAME_CYC; k++) begin
      checks++;
      if (q !== exp[k/CPB] || ready_out !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL a5_frame k=%0d got q=%b rdy=%b busy=%b want q=%b rdy=0 busy=1",
                 k, q, ready_out, busy, exp[k/CPB]);
      end
      step();
    end
    checks++;
    if (q !== 1'b1 || ready_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL a5_ready_return got q=%b rdy=%b busy=%b want 1 1 0", q, ready_out, busy);
    end
  endtask

  task automatic test_parity();
    logic [10:0] exp;
    exp = frame(8'h07, 1'b1);
    handshake(8'h07);
    for (int k = 0; k < FRAME_CYC; k++) begin
      checks++;
      if (q !== exp[k/CPB]) begin
        errors++;
        $display("FAIL p07_frame k=%0d got q=%b want q=%b", k, q, exp[k/CPB]);
      end
      step();
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL p07_ready_return got %b want 1", ready_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp0, exp1;
    exp0 = frame(8'h00, 1'b0);
    exp1 = frame(8'hFF, 1'b0);
    valid_in = 1'b1;
    data_in  = 8'h00;
    step();
    data_in  = 8'hFF;
    for (int k = 0; k < FRAME_CYC; k++) begin
      checks++;
      if (q !== exp0[k/CPB] || ready_out !== 1'b0) begin
        errors++;
        $display("FAIL b2b_first k=%0d got q=%b rdy=%b want q=%b rdy=0",
                 k, q, ready_out, exp0[k/CPB]);
      end
      step();
    end
    // Single idle-high gap cycle; the second handshake happens here.
    checks++;
    if (q !== 1'b1 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap got q=%b rdy=%b want 1 1", q, ready_out);
    end
    step();
    valid_in = 1'b0;
    data_in  = 8'h00;
    for (int k = 0; k < FRAME_CYC; k++) begin
      checks++;
      if (q !== exp1[k/CPB] || ready_out !== 1'b0) begin
        errors++;
        $display("FAIL b2b_second k=%0d got q=%b rdy=%b want q=%b rdy=0",
                 k, q, ready_out, exp1[k/CPB]);
      end
      step();
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_return got %b want 1", ready_out);
    end
  endtask

  task automatic test_stability();
    logic [10:0] exp;
    exp = frame(8'h96, 1'b0);
    handshake(8'h96);
    for (int k = 0; k < FRAME_CYC; k++) begin
      checks++;
      if (q !== exp[k/CPB] || busy !== 1'b1) begin
        errors++;
        $display("FAIL stab_frame k=%0d got q=%b busy=%b want q=%b busy=1",
                 k, q, busy, exp[k/CPB]);
      end
      data_in  = 8'($urandom);
      valid_in = (k % 3 == 0) && (k < FRAME_CYC - 1);
      step();
    end
    valid_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (q !== 1'b1 || ready_out !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL stab_no_extra cyc=%0d got q=%b rdy=%b busy=%b want 1 1 0",
                 i, q, ready_out, busy);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] exp;
    exp = frame(8'h5A, 1'b0);
    handshake(8'h5A);
    repeat (17) step();
    checks++;
    if (q !== exp[4] || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_data_bit3 got q=%b busy=%b want q=%b busy=1", q, busy, exp[4]);
    end
    reset = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'hFF;
    step();
    reset = 1'b0;
    valid_in = 1'b0;
    checks++;
    if (q !== 1'b1 || ready_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got q=%b rdy=%b busy=%b want 1 1 0", q, ready_out, busy);
    end
    step();
    exp = frame(8'h3C, 1'b0);
    handshake(8'h3C);
    for (int k = 0; k < FRAME_CYC; k++) begin
      checks++;
      if (q !== exp[k/CPB] || busy !== 1'b1) begin
        errors++;
        $display("FAIL after_reset_3c k=%0d got q=%b busy=%b want q=%b busy=1",
                 k, q, busy, exp[k/CPB]);
      end
      step();
    end
    checks++;
    if (ready_out !== 1'b1 || q !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_idle got q=%b rdy=%b want 1 1", q, ready_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    step();
    test_parity();
    step();
    test_back_to_back();
    step();
    test_stability();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-to-serial transmitter for the single-bit line that the team's registered receive flip-flops sample. It accepts one data word per valid/ready handshake and shifts out a UART-style frame: a start bit, the data bits LSB first, an optional parity bit and a stop bit. Each bit is held for a fixed number of clock cycles. It sits between a word producer (counter, test pattern source) and the 1-bit output pin or receive chain.

## Interface
- DATA_W, default 8: data bits per frame; must be ≥ 1.
- CLKS_PER_BIT, default 4: clock cycles each serial bit is held; must be ≥ 1.

- clock  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- data_in  input  DATA_W  word to transmit; sampled only on a handshake cycle.
- valid_in  input  1  producer offers data_in.
- ready_out  output  1  high exactly when state is IDLE.
- q  output  1  registered serial line; idles high.
- busy  output  1  high in every state except IDLE.

## Operation
- State machine: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- IDLE:
  - q=1.
  - A handshake (valid_in && ready_out) latches data_in into the shift register and moves to START.
  - valid_in without a handshake has no effect; there is no queueing.
- START: q=0 for CLKS_PER_BIT cycles.
- DATA:
  - q = shift_reg[0] for CLKS_PER_BIT cycles per bit, then the register shifts right.
  - A bit counter runs 0..DATA_W-1 and leaves the state after bit DATA_W-1.
- PARITY (PARITY_EN only): q = even parity (XOR of all latched data bits) for CLKS_PER_BIT cycles.
- STOP: q=1 for CLKS_PER_BIT cycles, then IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps at the end of every bit.
  - Width is clog2(CLKS_PER_BIT), minimum 1 bit.
  - CLKS_PER_BIT=1 is legal: one cycle per bit.
- Changes to data_in during a frame do not affect the frame.
- Reset values: q=1, ready_out=1, busy=0, state=IDLE, bit timer=0, bit counter=0, shift register=0.
- Reset mid-frame: the frame is abandoned. From the next cycle, q=1 and ready_out=1. No partial stop bit is sent.
- Reset has priority over a simultaneous handshake; that word is dropped.

## Timing
- Frame bits: F = DATA_W + 2 (F = DATA_W + 3 with PARITY_EN).
- Handshake at cycle T:
  - Start bit on q for cycles T+1 .. T+CLKS_PER_BIT.
  - Data bit i on q for cycles T+1+(i+1)·CLKS_PER_BIT .. T+(i+2)·CLKS_PER_BIT.
  - Stop bit occupies the last CLKS_PER_BIT cycles, ending at T+F·CLKS_PER_BIT.
  - ready_out=0 and busy=1 for cycles T+1 .. T+F·CLKS_PER_BIT.
  - ready_out=1 again at T+F·CLKS_PER_BIT+1.
- Back-to-back throughput: one word per F·CLKS_PER_BIT+1 cycles. There is exactly one idle-high cycle between frames.
- q is a flop output: no combinational path from any input to q.
- ready_out and busy depend only on state; no combinational path from valid_in.

## Configuration
- SERIAL_TX_PARITY_EN defined:
  - The PARITY state is compiled in.
  - An even-parity bit is sent after the last data bit.
  - F = DATA_W + 3.
- SERIAL_TX_PARITY_EN not defined:
  - No PARITY state and no parity logic.
  - STOP follows the last data bit directly.
  - F = DATA_W + 2.

## Test plan
All scenarios use DATA_W=8, CLKS_PER_BIT=4.
- Reset behaviour: hold reset 3 cycles, then release with valid_in=0 → q=1, ready_out=1, busy=0 for 20 cycles.
- Single frame: send 0xA5 → q = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles. ready_out=0 for 40 cycles and returns high at T+41. With PARITY_EN, a parity bit 0 precedes stop; ready_out returns high at T+45.
- Parity check (PARITY_EN): send 0x07 → data bits 1,1,1,0,0,0,0,0, then parity bit 1, then stop 1.
- Back-to-back: hold valid_in=1 with 0x00, then 0xFF → second start bit begins exactly one idle-high cycle after the first stop bit ends. The second frame carries eight 1s.
- data_in and valid_in stability:
  - Change data_in every cycle mid-frame → transmitted bits match the value latched at the handshake.
  - Pulse valid_in while busy → ignored; no extra frame.
- Reset mid-frame:
  - Assert reset during data bit 3 of 0x5A → next cycle q=1, ready_out=1, busy=0.
  - A new 0x3C handshake afterwards transmits a complete, correct frame.
